// File: rtl/io_uart_tx_if.sv
// Processor I/O bus slice seen by the UART transmitter: ADDR/Dout/W in, serial line and status out.
interface io_uart_tx_if;
  logic [8:0] ADDR;
  logic [8:0] Dout;
  logic       W;
  logic       tx;
  logic [8:0] status;
  logic       drop;

  modport master (output ADDR, Dout, W, input tx, status, drop);
  modport slave  (input ADDR, Dout, W, output tx, status, drop);
endinterface

// File: rtl/io_uart_tx.sv
// Memory-mapped serial transmitter: FIFO-buffered 9-bit frames with a programmable bit period.
// Optional even-parity bit enabled by defining IO_UART_TX_PARITY_EN.
module io_uart_tx #(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input logic         clk,
  input logic         resetn,
  io_uart_tx_if.slave bus
);

  localparam int unsigned PtrW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [8:0]  DivRst = 9'(CLKS_PER_BIT - 1);

`ifdef IO_UART_TX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  state_e            state_q;
  logic [8:0]        mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wptr_q, rptr_q;
  logic [CntW-1:0]   count_q;
  logic [8:0]        div_q, div_sh_q, bit_cnt_q, shift_q;
  logic [3:0]        idx_q;
  logic              tx_q, drop_q;
`ifdef IO_UART_TX_PARITY_EN
  logic              par_q;
`endif

  logic sel, wr_data, wr_ctrl, full, busy, push, pop, period_end;
  logic [8:0] head;
  logic unused_addr;

  // ADDR[6:1] are ignored so the register window aliases across the block.
  assign unused_addr = ^bus.ADDR[6:1];
  assign sel        = bus.ADDR[8] & ~bus.ADDR[7];
  assign wr_data    = sel & bus.W & ~bus.ADDR[0];
  assign wr_ctrl    = sel & bus.W & bus.ADDR[0];
  assign full       = (count_q == CntW'(FIFO_DEPTH));
  assign busy       = (state_q != StIdle);
  assign period_end = (bit_cnt_q == '0);
  assign head       = mem_q[rptr_q];

  // Pop from idle, or at the end of a stop bit so frames run back-to-back.
  assign pop  = (count_q != '0) & ((state_q == StIdle) | ((state_q == StStop) & period_end));
  assign push = wr_data & (~full | pop);

  assign bus.tx     = tx_q;
  assign bus.drop   = drop_q;
  assign bus.status = {4'b0, 3'(count_q), full, busy};

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= bus.Dout;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      drop_q  <= 1'b0;
      div_q   <= DivRst;
    end else begin
      if (push) wptr_q <= wptr_q + PtrW'(1);
      if (pop)  rptr_q <= rptr_q + PtrW'(1);
      if (push && !pop)      count_q <= count_q + CntW'(1);
      else if (pop && !push) count_q <= count_q - CntW'(1);
      drop_q <= wr_data & full & ~pop;
      if (wr_ctrl) div_q <= bus.Dout;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StIdle;
      tx_q      <= 1'b1;
      shift_q   <= '0;
      idx_q     <= '0;
      bit_cnt_q <= '0;
      div_sh_q  <= DivRst;
`ifdef IO_UART_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pop) begin
            state_q   <= StStart;
            tx_q      <= 1'b0;
            shift_q   <= head;
            div_sh_q  <= div_q;
            bit_cnt_q <= div_q;
`ifdef IO_UART_TX_PARITY_EN
            par_q     <= ^head;
`endif
          end
        end
        StStart: begin
          if (period_end) begin
            state_q   <= StData;
            tx_q      <= shift_q[0];
            idx_q     <= '0;
            bit_cnt_q <= div_sh_q;
          end else begin
            bit_cnt_q <= bit_cnt_q - 9'd1;
          end
        end
        StData: begin
          if (period_end) begin
            bit_cnt_q <= div_sh_q;
            if (idx_q == 4'd8) begin
`ifdef IO_UART_TX_PARITY_EN
              state_q <= StParity;
              tx_q    <= par_q;
`else
              state_q <= StStop;
              tx_q    <= 1'b1;
`endif
            end else begin
              idx_q   <= idx_q + 4'd1;
              shift_q <= shift_q >> 1;
              tx_q    <= shift_q[1];
            end
          end else begin
            bit_cnt_q <= bit_cnt_q - 9'd1;
          end
        end
`ifdef IO_UART_TX_PARITY_EN
        StParity: begin
          if (period_end) begin
            state_q   <= StStop;
            tx_q      <= 1'b1;
            bit_cnt_q <= div_sh_q;
          end else begin
            bit_cnt_q <= bit_cnt_q - 9'd1;
          end
        end
`endif
        StStop: begin
          if (period_end) begin
            if (pop) begin
              state_q   <= StStart;
              tx_q      <= 1'b0;
              shift_q   <= head;
              div_sh_q  <= div_q;
              bit_cnt_q <= div_q;
`ifdef IO_UART_TX_PARITY_EN
              par_q     <= ^head;
`endif
            end else begin
              state_q <= StIdle;
              tx_q    <= 1'b1;
            end
          end else begin
            bit_cnt_q <= bit_cnt_q - 9'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_io_uart_tx.sv
// Randomized bench for io_uart_tx against a frame-timeline model of the serial line.
module tb_io_uart_tx;

  localparam int Depth = 4;
  localparam int Cpb   = 4;
`ifdef IO_UART_TX_PARITY_EN
  localparam int Nb = 12;
`else
  localparam int Nb = 11;
`endif

  logic clk = 1'b0;
  logic resetn = 1'b0;
  io_uart_tx_if bus ();

  io_uart_tx #(.FIFO_DEPTH(Depth), .CLKS_PER_BIT(Cpb)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_checks = 0;
  int cycle = 0;

  // Model: queued words plus the frame in flight described by (word, period, start edge).
  int q[$];
  int div_m;
  bit active;
  int f_word, f_per, f_start;
  bit drop_m;

  task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  function automatic bit frame_bit(input int word, input int i);
    logic [8:0] w9;
    w9 = 9'(word);
    if (i == 0) return 1'b0;
    if (i <= 9) return w9[i-1];
    if (Nb == 12 && i == 10) return ^w9;
    return 1'b1;
  endfunction

  task automatic model_reset();
    q.delete();
    div_m  = Cpb - 1;
    active = 1'b0;
    drop_m = 1'b0;
  endtask

  task automatic model_step();
    bit sel, ending, pop;
    int old_div;
    sel     = bus.ADDR[8] & ~bus.ADDR[7];
    ending  = active && (cycle - f_start == Nb * f_per);
    pop     = (q.size() > 0) && (!active || ending);
    old_div = div_m;
    drop_m  = 1'b0;
    if (pop) begin
      f_word  = q.pop_front();
      f_per   = old_div + 1;
      f_start = cycle;
      active  = 1'b1;
    end else if (ending) begin
      active = 1'b0;
    end
    if (sel && bus.W && !bus.ADDR[0]) begin
      if (q.size() < Depth) q.push_back(int'(bus.Dout));
      else drop_m = 1'b1;
    end
    if (sel && bus.W && bus.ADDR[0]) div_m = int'(bus.Dout);
  endtask

  task automatic compare();
    logic exp_tx;
    logic [8:0] exp_st;
    exp_tx = active ? frame_bit(f_word, (cycle - f_start) / f_per) : 1'b1;
    exp_st = {4'b0, 3'(q.size()), q.size() == Depth, active};
    chk("tx", {8'b0, bus.tx}, {8'b0, exp_tx});
    chk("status", bus.status, exp_st);
    chk("drop", {8'b0, bus.drop}, {8'b0, drop_m});
  endtask

  task automatic tick();
    @(posedge clk);
    cycle++;
    if (!resetn) model_reset();
    else model_step();
    #1;
    compare();
  endtask

  task automatic cyc(input logic w, input logic [8:0] a, input logic [8:0] d);
    bus.W = w;
    bus.ADDR = a;
    bus.Dout = d;
    tick();
    bus.W = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 9'h000, 9'h000);
  endtask

  initial begin
    int exp_bits[12];
    exp_bits = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1, 1, 1};
    bus.W = 1'b0;
    bus.ADDR = '0;
    bus.Dout = '0;
    model_reset();
    tick();
    tick();
    resetn = 1'b1;

    // Reset and idle.
    idle(20);
    chk("idle_tx", {8'b0, bus.tx}, 9'h001);
    chk("idle_status", bus.status, 9'h000);

    // Single frame of 9'h1A5 at 4 clocks per bit.
    cyc(1'b1, 9'h100, 9'h1A5);
    chk("t2_queued", bus.status, 9'h004);
    for (int j = 0; j < Nb * 4; j++) begin
      idle(1);
      chk("t2_bit", {8'b0, bus.tx}, 9'(exp_bits[j / 4]));
      chk("t2_busy", {8'b0, bus.status[0]}, 9'h001);
    end
    idle(1);
    chk("t2_done", {8'b0, bus.status[0]}, 9'h000);
    idle(5);

    // Six back-to-back writes overflow a 4-deep FIFO.
    for (int i = 0; i < 6; i++) cyc(1'b1, (i % 2 == 0) ? 9'h100 : 9'h17E, 9'(9'h030 + i));
    chk("t3_drop", {8'b0, bus.drop}, 9'h001);
    chk("t3_full", {8'b0, bus.status[1]}, 9'h001);
    idle(1);
    chk("t3_drop_clr", {8'b0, bus.drop}, 9'h000);
    idle(5 * Nb * 4 + 10);

    // Divider change mid-frame only affects the next frame.
    cyc(1'b1, 9'h100, 9'h055);
    cyc(1'b1, 9'h100, 9'h0AA);
    idle(10);
    cyc(1'b1, 9'h101, 9'h002);
    idle(Nb * 4 + Nb * 3 + 20);

    // Async reset during DATA with two words queued.
    cyc(1'b1, 9'h100, 9'h0F0);
    cyc(1'b1, 9'h100, 9'h00F);
    cyc(1'b1, 9'h100, 9'h1C3);
    idle(10);
    #2;
    resetn = 1'b0;
    #1;
    chk("t5_async_tx", {8'b0, bus.tx}, 9'h001);
    chk("t5_async_status", bus.status, 9'h000);
    model_reset();
    tick();
    tick();
    resetn = 1'b1;
    idle(60);
    chk("t5_quiet", bus.status, 9'h000);

`ifdef IO_UART_TX_PARITY_EN
    cyc(1'b1, 9'h100, 9'h007);
    idle(37);
    chk("par_d8", {8'b0, bus.tx}, 9'h000);
    idle(4);
    chk("par_bit", {8'b0, bus.tx}, 9'h001);
    idle(20);
`endif

    // Random traffic, including aliased and unselected addresses.
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = int'($urandom_range(0, 31));
      if (r < 4) cyc(1'b1, {2'b10, 6'($urandom), 1'b0}, 9'($urandom));
      else if (r == 4) cyc(1'b1, {2'b10, 6'($urandom), 1'b1}, 9'($urandom_range(0, 3)));
      else if (r < 8) cyc(1'b1, {(r == 5) ? 2'b00 : ((r == 6) ? 2'b01 : 2'b11), 7'($urandom)},
                          9'($urandom));
      else idle(1);
    end
    idle(400);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/io_uart_tx.md
# io_uart_tx

Memory-mapped serial transmitter on the processor's I/O bus, in the address window next to the LED port (ADDR[8:7] = 2'b10). It consumes the same ADDR/Dout/W bus the processor drives for RAM and LEDs. Each write to its data register pushes one 9-bit word into a small FIFO. An FSM drains the FIFO and shifts each word out on `tx` as an asynchronous serial frame at a programmable bit period. A status word is exported for the system read mux.

## Interface
Parameters:
- FIFO_DEPTH, 4: word capacity; power of two, ≥2.
- CLKS_PER_BIT, 16: reset value of the bit period in clocks; 1..512.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- resetn  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- ADDR  in  9  processor address register output.
- Dout  in  9  processor data-out register.
- W  in  1  processor write strobe; high for one cycle per store.
- tx  out  1  serial line; idles high.
- status  out  9  {4'b0, count[2:0], full, busy}; combinational from registers.
- drop  out  1  one-cycle pulse when a data write hits a full FIFO.

## Operation
- Select: sel = ADDR[8] & ~ADDR[7]. ADDR[6:1] are ignored, so the window aliases.
- Data write (sel & W & ~ADDR[0]): pushes Dout into the FIFO. If the FIFO is full and no pop occurs that cycle, the word is discarded and `drop` pulses.
- Control write (sel & W & ADDR[0]): loads div ← Dout. Bit period = div+1 clocks, so div=0 gives 1 clock per bit. div resets to CLKS_PER_BIT-1.
- A new div value is sampled into a shadow register only on a pop. A frame in flight keeps its period.
- FIFO: circular, read and write pointers wrap modulo FIFO_DEPTH. count ranges 0..FIFO_DEPTH. full = (count==FIFO_DEPTH). A push and pop in the same cycle leaves count unchanged, and the push is accepted even when full.
- Frame: start bit (0), then 9 data bits LSB first, then stop bit (1). That is 11 bit periods.
- FSM states and transitions:
  - IDLE → START when count>0. Pops the head word into the shift register and loads the shadow div.
  - START → DATA after one bit period.
  - DATA: 9 bit periods, shift right each period; → STOP after bit 8.
  - STOP → START directly when count>0, popping on the same edge, so back-to-back frames have no gap. Otherwise STOP → IDLE.
- Counters: a bit-period counter runs down from shadow div to 0; a 4-bit data index counts 0..8. The bit period ends when the counter is 0.
- busy = (state != IDLE).

## Timing
- Reset values: tx=1, status=0, drop=0, state=IDLE, FIFO empty, pointers 0, div=CLKS_PER_BIT-1.
- Write accepted at edge k: count increments at edge k.
- From IDLE, the pop happens at edge k+1 and tx=0 from edge k+1. Latency from write to start bit is 1 clock.
- Each bit holds tx stable for exactly div+1 clocks.
- With default div, a full frame is 11·(div+1) clocks from start-bit edge to the end of stop.
- `drop` is asserted for the single cycle following the rejected write edge and is registered.
- Reset asserted mid-frame: tx goes to 1 immediately (asynchronously), the FIFO is flushed, and div returns to its reset value.
- A control write during a frame does not alter that frame's timing.
- W with sel=0 has no effect on any state.

## Configuration
- IO_UART_TX_PARITY_EN defined:
  - Adds a PARITY state between DATA and STOP, transmitting even parity (XOR of the 9 data bits).
  - Frame becomes 12 bit periods.
- Undefined: no PARITY state; 11-bit frame as above.

## Test plan
- Reset, then idle 20 clocks → tx=1, status=9'h000, drop never asserted.
- CLKS_PER_BIT=4: write 9'h1A5 to ADDR 9'h100 → tx=0 one clock later. tx then carries bits 1,0,1,0,0,1,0,1,1 LSB first, 4 clocks each, then stop=1. busy falls 44 clocks after the start edge.
- Write 6 words back-to-back with FIFO_DEPTH=4 while idle → first word popped after 1 clock. Words 1–5 fill the FIFO; word 6 sets drop=1 for 1 cycle and status.full=1. Five frames are sent with no idle gap between stop and start bits.
- Write div=9'h002 to ADDR 9'h101 mid-frame → current frame keeps a 4-clock period; the next frame uses a 3-clock period.
- Assert resetn=0 during DATA with 2 words queued → tx=1 asynchronously, status=0. After release, nothing is transmitted until a new write.
- With IO_UART_TX_PARITY_EN, send 9'h007 → parity bit 1 precedes stop; frame is 12 bit periods.
